pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_loaduse_cmp.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants, state encoding and control-bundle layout for the
// pipeline hazard controller and its load-use comparator.
package pipeline_hazard_ctrl_pkg;

  localparam int REGFILE_BITS = 5;
  localparam int DIV_CNT_BITS = 6;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    MISS_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idexe_stall;
    logic idexe_flush;
    logic exemem_stall;
    logic exemem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE    = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_LOADUSE = ctrl_t'(8'b1100_1000);
  localparam ctrl_t CTRL_BRANCH  = ctrl_t'(8'b0010_1000);
  localparam ctrl_t CTRL_DIV     = ctrl_t'(8'b1101_0010);
  localparam ctrl_t CTRL_MISS    = ctrl_t'(8'b1101_0101);

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Load-use detector: flags an ID-stage source that reads the destination
// of a load currently in EXE (x0 never creates a hazard).
module hazard_loaduse_cmp
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REGFILE_BITS-1:0] i_id_rs1,
  input  logic [REGFILE_BITS-1:0] i_id_rs2,
  input  logic                    i_id_use_rs1,
  input  logic                    i_id_use_rs2,
  input  logic [REGFILE_BITS-1:0] i_exe_rd,
  input  logic                    i_exe_is_ltype,
  output logic                    o_hit
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_exe_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_exe_rd);
  assign o_hit     = i_exe_is_ltype && (i_exe_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: priority miss > divide > branch > load-use.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [REGFILE_BITS-1:0] id_rs1,
  input  logic [REGFILE_BITS-1:0] id_rs2,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  input  logic [REGFILE_BITS-1:0] exe_rd,
  input  logic                    exe_is_ltype,
  input  logic                    exe_div_valid,
  input  logic                    exe_branch_taken,
  input  logic                    dcache_miss,
  input  logic                    dcache_ready,
  output logic                    pc_stall,
  output logic                    ifid_stall,
  output logic                    ifid_flush,
  output logic                    idexe_stall,
  output logic                    idexe_flush,
  output logic                    exemem_stall,
  output logic                    exemem_flush,
  output logic                    memwb_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             flush_events
`endif
);

  // The issue cycle is the first EXE cycle, so the counter covers the rest.
  localparam logic [DIV_CNT_BITS-1:0] DIV_LOAD = DIV_CNT_BITS'(DIV_CYCLES - 2);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [DIV_CNT_BITS-1:0] r_div_cnt;
  logic [DIV_CNT_BITS-1:0] w_div_cnt_nxt;
  logic                    r_resume_div;
  logic                    w_resume_div_nxt;
  logic                    w_loaduse;
  ctrl_t                   w_ctrl;

  hazard_loaduse_cmp u_loaduse_cmp (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_exe_rd      (exe_rd),
    .i_exe_is_ltype(exe_is_ltype),
    .o_hit         (w_loaduse)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_ctrl           = CTRL_NONE;
    w_state_nxt      = r_state;
    w_div_cnt_nxt    = r_div_cnt;
    w_resume_div_nxt = r_resume_div;
    case (r_state)
      RUN: begin
        if (dcache_miss) begin
          w_ctrl      = CTRL_MISS;
          w_state_nxt = MISS_WAIT;
          if (exe_div_valid) begin
            w_resume_div_nxt = 1'b1;
            w_div_cnt_nxt    = DIV_LOAD;
          end
        end else if (exe_div_valid) begin
          w_ctrl        = CTRL_DIV;
          w_state_nxt   = DIV_WAIT;
          w_div_cnt_nxt = DIV_LOAD;
        end else if (exe_branch_taken) begin
          w_ctrl = CTRL_BRANCH;
        end else if (w_loaduse) begin
          w_ctrl = CTRL_LOADUSE;
        end
      end
      DIV_WAIT: begin
        // A miss freezes the count so the divide resumes where it stopped.
        if (dcache_miss) begin
          w_ctrl           = CTRL_MISS;
          w_state_nxt      = MISS_WAIT;
          w_resume_div_nxt = 1'b1;
        end else if (r_div_cnt != '0) begin
          w_ctrl        = CTRL_DIV;
          w_div_cnt_nxt = r_div_cnt - DIV_CNT_BITS'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      MISS_WAIT: begin
        if (dcache_ready) begin
          w_state_nxt      = r_resume_div ? DIV_WAIT : RUN;
          w_resume_div_nxt = 1'b0;
        end else begin
          w_ctrl = CTRL_MISS;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
    if (!nrst) begin
      w_ctrl = CTRL_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= RUN;
      r_div_cnt    <= '0;
      r_resume_div <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_resume_div <= w_resume_div_nxt;
    end
  end

  assign pc_stall     = w_ctrl.pc_stall;
  assign ifid_stall   = w_ctrl.ifid_stall;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idexe_stall  = w_ctrl.idexe_stall;
  assign idexe_flush  = w_ctrl.idexe_flush;
  assign exemem_stall = w_ctrl.exemem_stall;
  assign exemem_flush = w_ctrl.exemem_flush;
  assign memwb_flush  = w_ctrl.memwb_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  // Saturating counters: they stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_ctrl.pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_ctrl.ifid_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DIV_CYCLES=33); the counter checks
// are compiled only when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  // Output vector order: pc,ifid_s,ifid_f,idexe_s,idexe_f,exemem_s,exemem_f,memwb_f
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1100_1000;
  localparam logic [7:0] E_BR   = 8'b0010_1000;
  localparam logic [7:0] E_DIV  = 8'b1101_0010;
  localparam logic [7:0] E_MISS = 8'b1101_0101;

  logic       clk = 1'b0;
  logic       nrst;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_use_rs1, id_use_rs2, exe_is_ltype, exe_div_valid;
  logic       exe_branch_taken, dcache_miss, dcache_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush;
  logic       exemem_stall, exemem_flush, memwb_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(.DIV_CYCLES(33)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .exe_rd          (exe_rd),
    .exe_is_ltype    (exe_is_ltype),
    .exe_div_valid   (exe_div_valid),
    .exe_branch_taken(exe_branch_taken),
    .dcache_miss     (dcache_miss),
    .dcache_ready    (dcache_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idexe_stall     (idexe_stall),
    .idexe_flush     (idexe_flush),
    .exemem_stall    (exemem_stall),
    .exemem_flush    (exemem_flush),
    .memwb_flush     (memwb_flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, idexe_stall,
            idexe_flush, exemem_stall, exemem_flush, memwb_flush};
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; exe_is_ltype = 1'b0;
    exe_div_valid = 1'b0; exe_branch_taken = 1'b0;
    dcache_miss = 1'b0; dcache_ready = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loaduse_rs2();
    exe_is_ltype = 1'b1; exe_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    nrst = 1'b0; exe_div_valid = 1'b1; dcache_miss = 1'b1; exe_branch_taken = 1'b1;
    #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL reset_outs_zero: got %b want %b", outs(), E_NONE);
    end
    tick();
    checks++;
    if (dut.r_state !== RUN || dut.r_div_cnt !== 6'd0 || dut.r_resume_div !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d cnt=%0d resume=%b want 0/0/0",
               dut.r_state, dut.r_div_cnt, dut.r_resume_div);
    end
    idle(); nrst = 1'b1;
    #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL reset_release_idle: got %b want %b", outs(), E_NONE);
    end
  endtask

  task automatic test_loaduse();
    tick(); idle(); set_loaduse_rs2(); #2;
    checks++;
    if (outs() !== E_LU) begin
      errors++; $display("FAIL loaduse_rs2: got %b want %b", outs(), E_LU);
    end
    tick(); idle(); #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL loaduse_one_cycle: got %b want %b", outs(), E_NONE);
    end
    tick(); idle(); set_loaduse_rs2(); exe_rd = 5'd0; id_rs2 = 5'd0; #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL loaduse_rd0: got %b want %b", outs(), E_NONE);
    end
    tick(); idle(); exe_is_ltype = 1'b1; exe_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; #2;
    checks++;
    if (outs() !== E_LU) begin
      errors++; $display("FAIL loaduse_rs1: got %b want %b", outs(), E_LU);
    end
    tick(); id_use_rs1 = 1'b0; #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL loaduse_src_unused: got %b want %b", outs(), E_NONE);
    end
    tick(); id_use_rs1 = 1'b1; exe_is_ltype = 1'b0; #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL loaduse_not_load: got %b want %b", outs(), E_NONE);
    end
  endtask

  task automatic test_branch();
    tick(); idle(); exe_branch_taken = 1'b1; #2;
    checks++;
    if (outs() !== E_BR) begin
      errors++; $display("FAIL branch_only: got %b want %b", outs(), E_BR);
    end
    tick(); set_loaduse_rs2(); #2;
    checks++;
    if (outs() !== E_BR) begin
      errors++; $display("FAIL branch_over_loaduse: got %b want %b", outs(), E_BR);
    end
  endtask

  task automatic test_divide();
    int run;
    tick(); idle(); exe_div_valid = 1'b1; exe_branch_taken = 1'b1; #2;
    checks++;
    if (outs() !== E_DIV) begin
      errors++; $display("FAIL div_issue_over_branch: got %b want %b", outs(), E_DIV);
    end
    exe_branch_taken = 1'b0;
    run = 0;
    while (idexe_stall && run < 40) begin
      run++; tick(); #2;
    end
    checks++;
    if (run !== 32) begin
      errors++; $display("FAIL div_stall_len: got %0d cycles want 32", run);
    end
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL div_last_cycle_low: got %b want %b", outs(), E_NONE);
    end
    tick(); idle(); #2;
    checks++;
    if (dut.r_state !== RUN || outs() !== E_NONE) begin
      errors++; $display("FAIL div_back_to_run: state=%0d outs=%b want RUN/%b",
                         dut.r_state, outs(), E_NONE);
    end
  endtask

  task automatic test_miss_in_div();
    int ms;
    int run;
    tick(); idle(); exe_div_valid = 1'b1; #2;
    tick(); exe_div_valid = 1'b0;
    repeat (21) tick();
    checks++;
    if (dut.r_div_cnt !== 6'd10) begin
      errors++; $display("FAIL div_cnt_at_10: got %0d want 10", dut.r_div_cnt);
    end
    dcache_miss = 1'b1; #2;
    checks++;
    if (outs() !== E_MISS) begin
      errors++; $display("FAIL miss_in_div: got %b want %b", outs(), E_MISS);
    end
    ms = 0;
    while (exemem_stall && ms < 20) begin
      ms++; tick(); dcache_miss = 1'b0;
      if (ms == 7) dcache_ready = 1'b1;
      #2;
    end
    checks++;
    if (ms !== 7) begin
      errors++; $display("FAIL miss_stall_len: got %0d cycles want 7", ms);
    end
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL miss_ready_low: got %b want %b", outs(), E_NONE);
    end
    tick(); dcache_ready = 1'b0; #2;
    checks++;
    if (dut.r_state !== DIV_WAIT || dut.r_div_cnt !== 6'd10 || outs() !== E_DIV) begin
      errors++; $display("FAIL div_resume: state=%0d cnt=%0d outs=%b want DIV_WAIT/10/%b",
                         dut.r_state, dut.r_div_cnt, outs(), E_DIV);
    end
    run = 0;
    while (idexe_stall && run < 40) begin
      run++; tick(); #2;
    end
    checks++;
    if (run !== 10) begin
      errors++; $display("FAIL resume_stall_len: got %0d cycles want 10", run);
    end
    tick(); #2;
    checks++;
    if (dut.r_state !== RUN || outs() !== E_NONE) begin
      errors++; $display("FAIL resume_done_run: state=%0d outs=%b want RUN/%b",
                         dut.r_state, outs(), E_NONE);
    end
  endtask

  task automatic test_back_to_back();
    tick(); idle(); exe_div_valid = 1'b1; dcache_miss = 1'b1; #2;
    checks++;
    if (outs() !== E_MISS) begin
      errors++; $display("FAIL miss_with_div_issue: got %b want %b", outs(), E_MISS);
    end
    tick(); idle(); dcache_ready = 1'b1; #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL coissue_ready_low: got %b want %b", outs(), E_NONE);
    end
    tick(); idle(); #2;
    checks++;
    if (dut.r_state !== DIV_WAIT || dut.r_div_cnt !== 6'd31 || outs() !== E_DIV) begin
      errors++; $display("FAIL coissue_div_loaded: state=%0d cnt=%0d outs=%b want DIV_WAIT/31/%b",
                         dut.r_state, dut.r_div_cnt, outs(), E_DIV);
    end
    tick(); nrst = 1'b0; #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL reset_mid_div_outs: got %b want %b", outs(), E_NONE);
    end
    tick(); nrst = 1'b1; #2;
    checks++;
    if (dut.r_state !== RUN || outs() !== E_NONE) begin
      errors++; $display("FAIL reset_mid_div_release: state=%0d outs=%b want RUN/%b",
                         dut.r_state, outs(), E_NONE);
    end
    tick(); #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL reset_mid_div_residual: got %b want %b", outs(), E_NONE);
    end
  endtask

  task automatic test_reset_mid_miss();
    tick(); idle(); dcache_miss = 1'b1; #2;
    checks++;
    if (outs() !== E_MISS) begin
      errors++; $display("FAIL miss_in_run: got %b want %b", outs(), E_MISS);
    end
    tick(); dcache_miss = 1'b0; nrst = 1'b0; #2;
    tick(); nrst = 1'b1; #2;
    checks++;
    if (dut.r_state !== RUN || outs() !== E_NONE) begin
      errors++; $display("FAIL reset_mid_miss_release: state=%0d outs=%b want RUN/%b",
                         dut.r_state, outs(), E_NONE);
    end
    tick(); #2;
    checks++;
    if (outs() !== E_NONE) begin
      errors++; $display("FAIL reset_mid_miss_residual: got %b want %b", outs(), E_NONE);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    tick(); idle(); nrst = 1'b0;
    tick(); nrst = 1'b1; #2;
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
      errors++; $display("FAIL perf_reset: stall=%0d flush=%0d want 0/0", stall_cycles, flush_events);
    end
    tick(); set_loaduse_rs2();
    tick(); idle(); exe_branch_taken = 1'b1;
    tick(); idle(); #2;
    checks++;
    if (stall_cycles !== 32'd1 || flush_events !== 16'd1) begin
      errors++; $display("FAIL perf_count: stall=%0d flush=%0d want 1/1", stall_cycles, flush_events);
    end
  endtask
`endif

  initial begin
    nrst = 1'b0;
    idle();
    repeat (2) tick();
    test_reset();
    test_loaduse();
    test_branch();
    test_divide();
    test_miss_in_div();
    test_back_to_back();
    test_reset_mid_miss();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
